// File: rtl/ahb_apb_bridge_if.sv
// AHB-Lite slave / APB master signal bundle for ahb_apb_bridge.
// The slave modport is the bridge's view (AHB slave that also drives the APB
// master signals); the master modport is the view of the surrounding system
// (AHB master plus the APB peripherals).
interface ahb_apb_bridge_if #(
  parameter int unsigned NUM_SLAVES = 4
);
  // AHB-Lite side
  logic                    HSEL;
  logic [31:0]             HADDR;
  logic [1:0]              HTRANS;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [31:0]             HWDATA;
  logic                    HREADY;
  logic                    HREADYOUT;
  logic                    HRESP;
  logic [31:0]             HRDATA;
  // APB side
  logic [NUM_SLAVES-1:0]   PSEL;
  logic                    PENABLE;
  logic [31:0]             PADDR;
  logic                    PWRITE;
  logic [31:0]             PWDATA;
  logic [3:0]              PSTRB;
  logic [NUM_SLAVES-1:0]   PREADY_S;
  logic [NUM_SLAVES-1:0]   PSLVERR_S;
  logic [32*NUM_SLAVES-1:0] PRDATA_S;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
           PREADY_S, PSLVERR_S, PRDATA_S,
    output HREADYOUT, HRESP, HRDATA,
           PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
           PREADY_S, PSLVERR_S, PRDATA_S,
    input  HREADYOUT, HRESP, HRDATA,
           PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB
  );
endinterface

// File: rtl/ahb_apb_bridge.sv
// Single-clock AHB-Lite to APB bridge: decodes a slot index from HADDR,
// runs the APB SETUP/ACCESS sequence on the selected slot and returns read
// data / error status, aborting an access that waits longer than TIMEOUT.
module ahb_apb_bridge #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SLOT_LSB   = 12,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic               PCLK,
  input logic               PRESETn,
  ahb_apb_bridge_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;

  state_t                state;
  logic                  hreadyout;
  logic                  hresp;
  logic [31:0]           hrdata;
  logic [NUM_SLAVES-1:0] psel;
  logic                  penable;
  logic [31:0]           paddr;
  logic                  pwrite;
  logic [31:0]           pwdata_q;
  logic [3:0]            pstrb;
  logic [9:0]            count;

  logic [3:0]            slot;
  logic                  xfer_req;
  logic [NUM_SLAVES-1:0] slot_onehot;
  logic [3:0]            strb;
  logic                  sel_ready;
  logic                  sel_err;
  logic [31:0]           sel_rdata;
  logic [9:0]            count_next;
  logic                  unused_htrans0;

  assign slot           = bus.HADDR[SLOT_LSB +: 4];
  assign xfer_req       = bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign count_next     = count + 10'd1;
  assign unused_htrans0 = bus.HTRANS[0];

  // Slot decode; an all-zero result marks an index beyond NUM_SLAVES.
  always_comb begin
    slot_onehot = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (32'(slot) == k) slot_onehot[k] = 1'b1;
    end
  end

  // Byte strobes from size and low address bits; reads carry no strobes.
  always_comb begin
    strb = '0;
    if (bus.HWRITE) begin
      case (bus.HSIZE)
        3'd0:    strb = 4'b0001 << bus.HADDR[1:0];
        3'd1:    strb = bus.HADDR[1] ? 4'b1100 : 4'b0011;
        default: strb = 4'b1111;
      endcase
    end
  end

  // Response mux from the slot currently selected by the registered PSEL.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (psel[k]) begin
        sel_ready = bus.PREADY_S[k];
        sel_err   = bus.PSLVERR_S[k];
        sel_rdata = bus.PRDATA_S[32*k +: 32];
      end
    end
  end

  // Bridge FSM with all AHB/APB outputs registered.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata_q  <= '0;
      pstrb     <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (xfer_req) begin
            hreadyout <= 1'b0;
            if (slot_onehot == '0) begin
              state <= ERR1;
              hresp <= 1'b1;
            end else begin
              state  <= SETUP;
              psel   <= slot_onehot;
              paddr  <= bus.HADDR;
              pwrite <= bus.HWRITE;
              pstrb  <= strb;
              count  <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          state    <= ACCESS;
          penable  <= 1'b1;
          pwdata_q <= bus.HWDATA;
        end
        ACCESS: begin
          count <= count_next;
          if (sel_ready) begin
            psel    <= '0;
            penable <= 1'b0;
            if (sel_err) begin
              state <= ERR1;
              hresp <= 1'b1;
            end else begin
              state     <= DONE;
              hreadyout <= 1'b1;
              if (!pwrite) hrdata <= sel_rdata;
            end
          end else if (count_next == 10'(TIMEOUT)) begin
            psel    <= '0;
            penable <= 1'b0;
            state   <= ERR1;
            hresp   <= 1'b1;
          end
        end
        ERR1: begin
          state     <= ERR2;
          hreadyout <= 1'b1;
        end
        ERR2: begin
          state <= IDLE;
          hresp <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PADDR     = paddr;
  assign bus.PWRITE    = pwrite;
  // Write data is visible in SETUP straight from HWDATA, then held from the register.
  assign bus.PWDATA    = (state == SETUP) ? bus.HWDATA : pwdata_q;
  assign bus.PSTRB     = pstrb;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Scoreboard bench for ahb_apb_bridge: the driver pushes the expected
// response of each transfer, a negedge monitor pops and compares it when the
// bridge completes (HREADYOUT rising) along with the APB phase it observed.
module tb_ahb_apb_bridge;
  localparam int unsigned NS = 4;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;

  ahb_apb_bridge_if #(.NUM_SLAVES(NS)) bus ();

  ahb_apb_bridge #(.NUM_SLAVES(NS), .SLOT_LSB(12), .TIMEOUT(4)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned lat;
    int unsigned en;
    logic [3:0]  psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } exp_t;

  exp_t        sbq[$];
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(input logic err, input logic [31:0] rdata, input int unsigned lat,
                              input int unsigned en, input logic [3:0] psel, input logic [31:0] paddr,
                              input logic pwrite, input logic [31:0] pwdata, input logic [3:0] pstrb);
    exp_t e;
    e.err = err; e.rdata = rdata; e.lat = lat; e.en = en; e.psel = psel;
    e.paddr = paddr; e.pwrite = pwrite; e.pwdata = pwdata; e.pstrb = pstrb;
    return e;
  endfunction

  // APB slave model: PREADY after wait_n ACCESS cycles, optional PSLVERR.
  int unsigned wait_n  = 0;
  logic        slv_err = 1'b0;
  logic [31:0] rd_word = '0;
  int unsigned acc_cnt = 0;

  always @(posedge PCLK) acc_cnt <= (bus.PSEL != '0 && bus.PENABLE) ? acc_cnt + 1 : 0;

  assign bus.HREADY    = bus.HREADYOUT;
  assign bus.PREADY_S  = (bus.PENABLE && acc_cnt >= wait_n) ? bus.PSEL : '0;
  assign bus.PSLVERR_S = slv_err ? bus.PREADY_S : '0;

  always_comb begin
    bus.PRDATA_S = '0;
    for (int k = 0; k < int'(NS); k++)
      bus.PRDATA_S[32*k +: 32] = bus.PSEL[k] ? rd_word : (32'hBAD0_0000 | 32'(k));
  end

  // Monitor state
  int unsigned cyc = 0, acc_edge = 0, en_cnt = 0;
  logic        prev_rdy = 1'b1, prev_resp = 1'b0, prev_en = 1'b0;
  logic        psel_seen = 1'b0, setup_ok = 1'b0;
  logic [3:0]  prev_psel = '0;
  logic [31:0] prev_pwdata = '0;
  logic [3:0]  s_psel = '0, s_pstrb = '0;
  logic [31:0] s_paddr = '0, s_pwdata = '0, s_pwdata_setup = '0;
  logic        s_pwrite = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    exp_t e;
    if (!PRESETn) begin
      prev_rdy = 1'b1; prev_resp = 1'b0; prev_en = 1'b0; prev_psel = '0;
      en_cnt = 0; psel_seen = 1'b0;
    end else begin
      if (bus.PENABLE) en_cnt++;
      if (bus.PSEL != '0) psel_seen = 1'b1;
      if (bus.PENABLE && !prev_en) begin
        s_psel = bus.PSEL; s_paddr = bus.PADDR; s_pwrite = bus.PWRITE;
        s_pwdata = bus.PWDATA; s_pstrb = bus.PSTRB;
        s_pwdata_setup = prev_pwdata;
        setup_ok = (prev_psel == bus.PSEL);
      end
      if (bus.HREADYOUT && !prev_rdy) begin
        if (sbq.size() == 0) check("sb_unexpected_completion", 32'(sbq.size()), 32'd1);
        else begin
          e = sbq.pop_front();
          check("hresp_pair", 32'({prev_resp, bus.HRESP}), 32'({e.err, e.err}));
          check("latency", cyc - acc_edge + 1, e.lat);
          check("hrdata", bus.HRDATA, e.rdata);
          check("penable_cycles", en_cnt, e.en);
          check("psel_seen", 32'(psel_seen), 32'(e.en != 0));
          if (e.en != 0) begin
            check("setup_phase", 32'(setup_ok), 32'd1);
            check("psel", 32'(s_psel), 32'(e.psel));
            check("paddr", s_paddr, e.paddr);
            check("pwrite", 32'(s_pwrite), 32'(e.pwrite));
            check("pstrb", 32'(s_pstrb), 32'(e.pstrb));
            if (e.pwrite) begin
              check("pwdata", s_pwdata, e.pwdata);
              check("pwdata_setup", s_pwdata_setup, e.pwdata);
            end
          end
        end
      end
      if (bus.HSEL && bus.HTRANS[1] && bus.HREADYOUT && !bus.HRESP) begin
        acc_edge = cyc + 1;
        en_cnt = 0;
        psel_seen = 1'b0;
      end
      prev_rdy = bus.HREADYOUT; prev_resp = bus.HRESP; prev_en = bus.PENABLE;
      prev_psel = bus.PSEL; prev_pwdata = bus.PWDATA;
    end
  end

  // Issue one transfer; called and returning at 1 time unit after a rising edge.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd,
                      input int unsigned wt, input logic se, input logic [31:0] rw,
                      input logic push, input exp_t e);
    int unsigned n = 0;
    if (push) sbq.push_back(e);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = a; bus.HWRITE = w; bus.HSIZE = sz;
    do begin @(negedge PCLK); n++; end while (!(bus.HREADYOUT && !bus.HRESP) && n < 40);
    if (n >= 40) begin
      checks++; fails++;
      $display("FAIL accept_wait: addr 0x%08h not accepted within 40 cycles", a);
    end
    @(posedge PCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = wd;
    wait_n = wt; slv_err = se; rd_word = rw;
  endtask

  initial begin
    int unsigned n;
    exp_t none;
    none = mk(1'b0, '0, 0, 0, '0, '0, 1'b0, '0, '0);
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'd0; bus.HWDATA = '0;
    #12;
    check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("rst_hresp", 32'(bus.HRESP), 32'd0);
    check("rst_hrdata", bus.HRDATA, 32'd0);
    check("rst_psel", 32'(bus.PSEL), 32'd0);
    check("rst_penable", 32'(bus.PENABLE), 32'd0);
    check("rst_paddr", bus.PADDR, 32'd0);
    check("rst_pwrite", 32'(bus.PWRITE), 32'd0);
    check("rst_pwdata", bus.PWDATA, 32'd0);
    check("rst_pstrb", 32'(bus.PSTRB), 32'd0);
    @(posedge PCLK); #2 PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // word / byte / half-word writes, zero-wait
    xfer(32'h0000_1004, 1'b1, 3'd2, 32'hA5A5_1234, 0, 1'b0, '0, 1'b1,
         mk(1'b0, 32'h0, 3, 1, 4'b0010, 32'h0000_1004, 1'b1, 32'hA5A5_1234, 4'b1111));
    xfer(32'h0000_0003, 1'b1, 3'd0, 32'h1122_3344, 0, 1'b0, '0, 1'b1,
         mk(1'b0, 32'h0, 3, 1, 4'b0001, 32'h0000_0003, 1'b1, 32'h1122_3344, 4'b1000));
    xfer(32'h0000_0002, 1'b1, 3'd1, 32'h5566_7788, 0, 1'b0, '0, 1'b1,
         mk(1'b0, 32'h0, 3, 1, 4'b0001, 32'h0000_0002, 1'b1, 32'h5566_7788, 4'b1100));
    xfer(32'h0000_3001, 1'b1, 3'd0, 32'h0000_00C3, 0, 1'b0, '0, 1'b1,
         mk(1'b0, 32'h0, 3, 1, 4'b1000, 32'h0000_3001, 1'b1, 32'h0000_00C3, 4'b0010));
    // read slot 2 with three wait states
    xfer(32'h0000_2010, 1'b0, 3'd2, '0, 3, 1'b0, 32'hDEAD_BEEF, 1'b1,
         mk(1'b0, 32'hDEAD_BEEF, 6, 4, 4'b0100, 32'h0000_2010, 1'b0, '0, 4'b0000));
    // slot 7 does not exist
    xfer(32'h0000_7000, 1'b0, 3'd2, '0, 0, 1'b0, '0, 1'b1,
         mk(1'b1, 32'hDEAD_BEEF, 2, 0, '0, '0, 1'b0, '0, '0));
    // slave error
    xfer(32'h0000_0008, 1'b1, 3'd2, 32'hCAFE_0001, 0, 1'b1, '0, 1'b1,
         mk(1'b1, 32'hDEAD_BEEF, 4, 1, 4'b0001, 32'h0000_0008, 1'b1, 32'hCAFE_0001, 4'b1111));
    // hung slave, TIMEOUT=4
    xfer(32'h0000_1000, 1'b0, 3'd2, '0, 100, 1'b0, '0, 1'b1,
         mk(1'b1, 32'hDEAD_BEEF, 7, 4, 4'b0010, 32'h0000_1000, 1'b0, '0, 4'b0000));
    // back-to-back write then read, second accepted in DONE
    xfer(32'h0000_2004, 1'b1, 3'd2, 32'h0BAD_F00D, 0, 1'b0, '0, 1'b1,
         mk(1'b0, 32'hDEAD_BEEF, 3, 1, 4'b0100, 32'h0000_2004, 1'b1, 32'h0BAD_F00D, 4'b1111));
    xfer(32'h0000_3008, 1'b0, 3'd2, '0, 0, 1'b0, 32'h1234_5678, 1'b1,
         mk(1'b0, 32'h1234_5678, 3, 1, 4'b1000, 32'h0000_3008, 1'b0, '0, 4'b0000));

    // asynchronous reset during ACCESS
    xfer(32'h0000_1010, 1'b0, 3'd2, '0, 100, 1'b0, '0, 1'b0, none);
    n = 0;
    do begin @(negedge PCLK); n++; end while (!bus.PENABLE && n < 10);
    check("access_reached", 32'(bus.PENABLE), 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    check("arst_psel", 32'(bus.PSEL), 32'd0);
    check("arst_penable", 32'(bus.PENABLE), 32'd0);
    check("arst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("arst_hresp", 32'(bus.HRESP), 32'd0);
    check("arst_hrdata", bus.HRDATA, 32'd0);
    @(negedge PCLK);
    @(posedge PCLK); #2 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(32'h0000_1008, 1'b1, 3'd1, 32'h0000_BEEF, 0, 1'b0, '0, 1'b1,
         mk(1'b0, 32'h0, 3, 1, 4'b0010, 32'h0000_1008, 1'b1, 32'h0000_BEEF, 4'b0011));

    repeat (12) @(negedge PCLK);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
Single-clock AHB-Lite slave to APB master bridge. It sits directly upstream of the UART APB wrapper and the other APB peripherals. It decodes a slot index from HADDR, drives a one-hot PSEL to the selected peripheral and runs the APB SETUP/ACCESS sequence. It returns read data and error status to the AHB side, with a wait-state timeout so a hung slave cannot stall the bus.

Parameters:
NUM_SLAVES, 4, number of APB slots; the one-hot PSEL width.
SLOT_LSB, 12, lowest HADDR bit of the slot index; index = HADDR[SLOT_LSB+3:SLOT_LSB].
TIMEOUT, 255, maximum ACCESS cycles spent waiting for PREADY before abort (range 1..1023).

Ports:
PCLK  in  1  single clock for both the AHB and APB sides.
PRESETn  in  1  asynchronous active-low reset.
HSEL  in  1  AHB slave select.
HADDR  in  32  AHB address.
HTRANS  in  2  AHB transfer type; only NONSEQ and SEQ (HTRANS[1]=1) start a transfer.
HWRITE  in  1  AHB write (1) or read (0).
HSIZE  in  3  AHB transfer size: 0 = byte, 1 = half-word, 2 = word.
HWDATA  in  32  AHB write data, valid in the data phase.
HREADY  in  1  AHB bus ready.
HREADYOUT  out  1  bridge ready.
HRESP  out  1  error response (1 = ERROR).
HRDATA  out  32  read data.
PSEL  out  NUM_SLAVES  one-hot APB select.
PENABLE  out  1  APB enable.
PADDR  out  32  registered AHB address.
PWRITE  out  1  APB write.
PWDATA  out  32  APB write data.
PSTRB  out  4  APB byte strobes.
PREADY_S  in  NUM_SLAVES  per-slot PREADY.
PSLVERR_S  in  NUM_SLAVES  per-slot PSLVERR.
PRDATA_S  in  32*NUM_SLAVES  per-slot PRDATA; slot k occupies bits [32k+31:32k].

Behaviour:
- Reset values: state IDLE; HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, timeout counter 0.
- Acceptance: a transfer is accepted on a rising edge where HSEL & HREADY & HTRANS[1] holds, in IDLE or DONE only. On acceptance, HADDR, HWRITE, HSIZE and the slot index are registered.
- Slot index >= NUM_SLAVES: go to ERR1. No APB access; PSEL stays 0.
- Valid slot: go to SETUP.
- SETUP (1 cycle):
  - PSEL[idx]=1, PENABLE=0, HREADYOUT=0.
  - PWDATA follows HWDATA combinationally; HWDATA is registered at the end of SETUP.
  - PSTRB for writes: HSIZE=0 gives 1<<HADDR[1:0]; HSIZE=1 gives 0011 or 1100 by HADDR[1]; HSIZE=2 gives 1111. PSTRB=0000 for reads.
  - Next state: ACCESS.
- ACCESS:
  - PSEL and PENABLE=1; PWDATA is taken from the register; all APB outputs are held stable. The counter increments every cycle.
  - PREADY_S[idx]=1 and PSLVERR_S[idx]=0: latch PRDATA_S slot into HRDATA on reads, HRDATA unchanged on writes; go to DONE.
  - PREADY_S[idx]=1 and PSLVERR_S[idx]=1: go to ERR1.
  - Counter reaches TIMEOUT with PREADY still 0: go to ERR1. PSEL and PENABLE drop on the same edge (abort).
  - PSEL and PENABLE drop on leaving ACCESS.
- DONE (1 cycle): HREADYOUT=1, HRESP=0, HRDATA valid. A new transfer may be accepted in this cycle (back-to-back). Otherwise go to IDLE.
- ERR1: HREADYOUT=0, HRESP=1. Next state: ERR2.
- ERR2: HREADYOUT=1, HRESP=1. Next state: IDLE. New transfers are ignored in ERR2 (the AHB master cancels its pipelined transfer on ERROR).
- IDLE: HREADYOUT=1, HRESP=0. IDLE and BUSY HTRANS values, and HSEL=0, produce no action.
- Latency, accept edge to HREADYOUT=1 with zero-wait slave: 3 cycles (SETUP, ACCESS, DONE). Each slave wait state adds 1 cycle.
- The counter is cleared on entry to SETUP.
- Asynchronous reset asserted mid-transfer returns to the reset values immediately; PSEL and PENABLE drop without completing the APB access.
- HRDATA holds its last value outside DONE.

Test Plan:
- Word write, HADDR=0x0000_1004 (slot 1), HWDATA=0xA5A5_1234, slave PREADY=1 -> PSEL=0010 for 2 cycles, PENABLE=1 in the 2nd, PADDR=0x1004, PSTRB=1111, PWDATA=0xA5A5_1234; HREADYOUT=1 three cycles after accept.
- Byte write to 0x0000_0003, HSIZE=0 -> PSTRB=1000. Half-word write to 0x0000_0002 -> PSTRB=1100.
- Read from slot 2 with PREADY low for 3 ACCESS cycles, then PRDATA=0xDEAD_BEEF -> PENABLE high for 4 cycles, HRDATA=0xDEAD_BEEF in DONE, total latency 6 cycles.
- Read of 0x0000_7000 (slot 7, NUM_SLAVES=4) -> PSEL stays 0; HRESP=1 for 2 cycles with HREADYOUT 0 then 1.
- Slave asserts PSLVERR=1 with PREADY=1 -> two-cycle ERROR response. With TIMEOUT=4 and PREADY held 0 -> abort after 4 ACCESS cycles, two-cycle ERROR response.
- Back-to-back write then read accepted in the DONE cycle -> second SETUP immediately follows DONE. PRESETn pulled low during ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1 asynchronously.
